// File: rtl/ccu_req_arbiter.sv
// -----------------------------------------------------------------------------
// ccu_req_arbiter_pkg
//   Default ACE request/response types used when the arbiter is instantiated
//   without explicit type overrides. The ID field is always the leading (most
//   significant) member of the AR/AW/R/B channel structs, which is what lets the
//   arbiter prepend or strip the master index with a plain concatenation/slice.
//
// ccu_req_arbiter
//   Serializes ACE read/write requests from NoMstPorts cache masters onto the
//   single request port of the cache-coherency-unit FSM. One master is granted
//   at a time and the grant is held until that transaction fully completes
//   (last R beat, or B response, or B plus atomic R data). Round-robin
//   priority advances only when a transaction completes.
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous, active-high reset
//   slv_req_i   in   [NoMstPorts] requests from the cache masters
//   slv_resp_o  out  [NoMstPorts] responses to the cache masters
//   mst_req_o   out  request to the CCU FSM (ID widened by IdxW index bits)
//   mst_resp_i  in   response from the CCU FSM
// -----------------------------------------------------------------------------

package ccu_req_arbiter_pkg;

    localparam int unsigned DefIdW  = 4;
    localparam int unsigned DefIdxW = 2;
    localparam int unsigned MstIdW  = DefIdW + DefIdxW;

    typedef struct packed {
        logic [DefIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } slv_ar_chan_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } mst_ar_chan_t;

    typedef struct packed {
        logic [DefIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [5:0]        atop;
    } slv_aw_chan_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [5:0]        atop;
    } mst_aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [DefIdW-1:0] id;
        logic [1:0]        resp;
    } slv_b_chan_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [1:0]        resp;
    } mst_b_chan_t;

    typedef struct packed {
        logic [DefIdW-1:0] id;
        logic [31:0]       data;
        logic [1:0]        resp;
        logic              last;
    } slv_r_chan_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       data;
        logic [1:0]        resp;
        logic              last;
    } mst_r_chan_t;

    typedef struct packed {
        slv_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        slv_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } ace_slv_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        slv_b_chan_t  b;
        logic         r_valid;
        slv_r_chan_t  r;
    } ace_slv_resp_t;

    typedef struct packed {
        mst_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        mst_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } ace_mst_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        mst_b_chan_t  b;
        logic         r_valid;
        mst_r_chan_t  r;
    } ace_mst_resp_t;

endpackage

module ccu_req_arbiter #(
    parameter int unsigned NoMstPorts = 4,
    parameter type slv_req_t  = ccu_req_arbiter_pkg::ace_slv_req_t,
    parameter type slv_resp_t = ccu_req_arbiter_pkg::ace_slv_resp_t,
    parameter type mst_req_t  = ccu_req_arbiter_pkg::ace_mst_req_t,
    parameter type mst_resp_t = ccu_req_arbiter_pkg::ace_mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  slv_req_t  slv_req_i  [NoMstPorts],
    output slv_resp_t slv_resp_o [NoMstPorts],
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
);

    localparam int unsigned IdxW = $clog2(NoMstPorts);

    typedef enum logic [2:0] {
        IDLE,
        AR_FWD,
        R_FWD,
        AW_FWD,
        WB_FWD,
        ATOP_R
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       gnt_q, gnt_d;
    logic [IdxW-1:0]       rr_q, rr_d;
    logic                  atop_q, atop_d;

    logic [NoMstPorts-1:0] req;
    logic                  req_any;
    logic [IdxW-1:0]       win_idx;
    logic [IdxW-1:0]       rr_next;

    // Round-robin pick: scan offsets from the highest down so the candidate
    // closest to rr_q (offset 0) is the last one written and therefore wins.
    always_comb begin
        int unsigned cand;
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path can leave it holding its old value (latch).
        req     = '0;
        req_any = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NoMstPorts; i++) begin
            req[i] = slv_req_i[i].ar_valid | slv_req_i[i].aw_valid;
        end
        for (int off = NoMstPorts - 1; off >= 0; off--) begin
            cand = (32'(rr_q) + 32'(off)) % NoMstPorts;
            if (req[IdxW'(cand)]) begin
                win_idx = IdxW'(cand);
                req_any = 1'b1;
            end
        end
    end

    // Priority moves just past the master that finished, so its next request
    // has to wait for every other requester first.
    assign rr_next = (32'(gnt_q) == NoMstPorts - 1) ? '0 : gnt_q + 1'b1;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from the values seen before the edge.
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            atop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            atop_q  <= atop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        atop_d  = atop_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d = win_idx;
                    // A master presenting both AR and AW is served read first.
                    if (slv_req_i[win_idx].ar_valid) begin
                        state_d = AR_FWD;
                    end else begin
                        state_d = AW_FWD;
                        atop_d  = slv_req_i[win_idx].aw.atop[5];
                    end
                end
            end
            AR_FWD: begin
                if (slv_req_i[gnt_q].ar_valid && mst_resp_i.ar_ready) begin
                    state_d = R_FWD;
                end
            end
            R_FWD, ATOP_R: begin
                if (mst_resp_i.r_valid && slv_req_i[gnt_q].r_ready && mst_resp_i.r.last) begin
                    state_d = IDLE;
                    rr_d    = rr_next;
                end
            end
            AW_FWD: begin
                if (slv_req_i[gnt_q].aw_valid && mst_resp_i.aw_ready) begin
                    state_d = WB_FWD;
                end
            end
            WB_FWD: begin
                if (mst_resp_i.b_valid && slv_req_i[gnt_q].b_ready) begin
                    // Atomics that return data continue with an R burst.
                    if (atop_q) begin
                        state_d = ATOP_R;
                    end else begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output routing: only the granted master is connected, everything else
    // (including every port while IDLE) sees zeros.
    always_comb begin
        mst_req_o = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            slv_resp_o[i] = '0;
        end
        unique case (state_q)
            AR_FWD: begin
                // ID is the leading field, so the index lands in the ID MSBs.
                mst_req_o.ar                 = {gnt_q, slv_req_i[gnt_q].ar};
                mst_req_o.ar_valid           = slv_req_i[gnt_q].ar_valid;
                slv_resp_o[gnt_q].ar_ready   = mst_resp_i.ar_ready;
            end
            R_FWD, ATOP_R: begin
                // Dropping the top bits removes the prepended index from the ID.
                slv_resp_o[gnt_q].r          = mst_resp_i.r[$bits(slv_resp_o[0].r)-1:0];
                slv_resp_o[gnt_q].r_valid    = mst_resp_i.r_valid;
                mst_req_o.r_ready            = slv_req_i[gnt_q].r_ready;
            end
            AW_FWD: begin
                mst_req_o.aw                 = {gnt_q, slv_req_i[gnt_q].aw};
                mst_req_o.aw_valid           = slv_req_i[gnt_q].aw_valid;
                slv_resp_o[gnt_q].aw_ready   = mst_resp_i.aw_ready;
            end
            WB_FWD: begin
                mst_req_o.w                  = slv_req_i[gnt_q].w;
                mst_req_o.w_valid            = slv_req_i[gnt_q].w_valid;
                slv_resp_o[gnt_q].w_ready    = mst_resp_i.w_ready;
                slv_resp_o[gnt_q].b          = mst_resp_i.b[$bits(slv_resp_o[0].b)-1:0];
                slv_resp_o[gnt_q].b_valid    = mst_resp_i.b_valid;
                mst_req_o.b_ready            = slv_req_i[gnt_q].b_ready;
            end
            default: ;
        endcase
    end

    // The CCU echoes the widened ID; its index bits must name the master
    // currently holding the grant, otherwise a response would be misrouted.
    a_r_id_matches_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_q == R_FWD || state_q == ATOP_R) && mst_resp_i.r_valid)
        |-> (mst_resp_i.r[$bits(mst_resp_i.r)-1 -: IdxW] == gnt_q));

    a_b_id_matches_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == WB_FWD && mst_resp_i.b_valid)
        |-> (mst_resp_i.b[$bits(mst_resp_i.b)-1 -: IdxW] == gnt_q));

endmodule

// File: tb/tb_ccu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ccu_req_arbiter
//   Self-checking bench for ccu_req_arbiter. The bench plays both the cache
//   masters (request slots per master, one read and one write) and the CCU
//   (ready/valid responses, R/W/B beats). A transaction-level reference model
//   tracks which master should own the CCU, which phase of the transaction is
//   in flight and the round-robin pointer, and every cycle compares the DUT's
//   routing against it.
// -----------------------------------------------------------------------------

module tb_ccu_req_arbiter;
    import ccu_req_arbiter_pkg::*;

    localparam int NUM  = 4;
    localparam int WDOG = 400;

    localparam int P_REQ = 0;
    localparam int P_R   = 1;
    localparam int P_W   = 2;
    localparam int P_B   = 3;

    typedef struct {
        bit          valid;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        bit          atop;
    } slot_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    ace_slv_req_t  slv_req  [NUM];
    ace_slv_resp_t slv_resp [NUM];
    ace_mst_req_t  mst_req;
    ace_mst_resp_t mst_resp;

    ccu_req_arbiter #(
        .NoMstPorts (NUM)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    always #5 clk_i = ~clk_i;

    int    n_checks = 0;
    int    n_fail   = 0;

    slot_t rd_slot [NUM];
    slot_t wr_slot [NUM];

    // Reference model state.
    bit    active;
    int    g;
    int    kind;          // 0 read, 1 write
    slot_t cur;
    int    phase;
    int    beat;
    bit    is_atop_r;
    bit    first;
    int    busy;
    int    rr;
    int    done_cnt;
    int    atop_beats;
    int    mode;          // 0 none, 1 random all, 2 masters 0 and 3 always reading
    int    grant_log [$];
    int    kind_log  [$];

    // Per-cycle random handshake choices.
    bit    ccu_ar_ready, ccu_aw_ready, ccu_w_ready, ccu_r_valid, m_w_valid;
    bit    m_r_ready [NUM];
    bit    m_b_ready [NUM];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t new_txn(input bit is_wr);
        slot_t s;
        s.valid = 1'b1;
        s.id    = 4'($urandom_range(0, 15));
        s.addr  = $urandom & 32'hFFFF_FFF0;
        s.len   = 8'($urandom_range(0, 3));
        s.atop  = is_wr && ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM; i++) p |= rd_slot[i].valid | wr_slot[i].valid;
        return p;
    endfunction

    function automatic int rlen();
        return is_atop_r ? 0 : int'(cur.len);
    endfunction

    function automatic logic [31:0] r_data_exp();
        return is_atop_r ? ~cur.addr : cur.addr + 32'(beat);
    endfunction

    task automatic inject();
        for (int i = 0; i < NUM; i++) begin
            if (mode == 1) begin
                if (!rd_slot[i].valid && $urandom_range(0, 7) == 0) rd_slot[i] = new_txn(1'b0);
                if (!wr_slot[i].valid && $urandom_range(0, 7) == 0) wr_slot[i] = new_txn(1'b1);
            end else if (mode == 2 && (i == 0 || i == 3)) begin
                if (!rd_slot[i].valid) rd_slot[i] = new_txn(1'b0);
            end
        end
    endtask

    task automatic drive();
        ccu_ar_ready = ($urandom_range(0, 2) != 0);
        ccu_aw_ready = ($urandom_range(0, 2) != 0);
        ccu_w_ready  = ($urandom_range(0, 2) != 0);
        ccu_r_valid  = ($urandom_range(0, 2) != 0);
        m_w_valid    = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < NUM; i++) begin
            m_r_ready[i] = ($urandom_range(0, 2) != 0);
            m_b_ready[i] = ($urandom_range(0, 2) != 0);
            slv_req[i]             = '0;
            slv_req[i].ar_valid    = rd_slot[i].valid;
            slv_req[i].ar.id       = rd_slot[i].id;
            slv_req[i].ar.addr     = rd_slot[i].addr;
            slv_req[i].ar.len      = rd_slot[i].len;
            slv_req[i].ar.size     = 3'd2;
            slv_req[i].ar.burst    = 2'd1;
            slv_req[i].aw_valid    = wr_slot[i].valid;
            slv_req[i].aw.id       = wr_slot[i].id;
            slv_req[i].aw.addr     = wr_slot[i].addr;
            slv_req[i].aw.len      = wr_slot[i].len;
            slv_req[i].aw.size     = 3'd2;
            slv_req[i].aw.burst    = 2'd1;
            slv_req[i].aw.atop     = {wr_slot[i].atop, 5'd0};
            slv_req[i].r_ready     = m_r_ready[i];
            slv_req[i].b_ready     = m_b_ready[i];
        end
        mst_resp          = '0;
        mst_resp.ar_ready = ccu_ar_ready;
        mst_resp.aw_ready = ccu_aw_ready;
        mst_resp.w_ready  = ccu_w_ready;
        if (active && phase == P_W) begin
            slv_req[g].w_valid  = m_w_valid;
            slv_req[g].w.data   = cur.addr + 32'(beat);
            slv_req[g].w.strb   = 4'hF;
            slv_req[g].w.last   = (beat == int'(cur.len));
        end
        if (active && phase == P_R) begin
            mst_resp.r_valid   = ccu_r_valid;
            mst_resp.r.id      = {2'(g), cur.id};
            mst_resp.r.data    = r_data_exp();
            mst_resp.r.last    = (beat == rlen());
        end
        if (active && phase == P_B) begin
            mst_resp.b_valid   = 1'b1;
            mst_resp.b.id      = {2'(g), cur.id};
        end
    endtask

    task automatic complete();
        active = 1'b0;
        rr     = (g + 1) % NUM;
        done_cnt++;
    endtask

    task automatic evaluate();
        logic q;
        if (!active) begin
            q = |mst_req;
            for (int i = 0; i < NUM; i++) q |= |slv_resp[i];
            check("idle_quiet", 64'(q), 64'(0));
            for (int off = 0; off < NUM; off++) begin
                int c;
                c = (rr + off) % NUM;
                if (rd_slot[c].valid || wr_slot[c].valid) begin
                    g         = c;
                    kind      = rd_slot[c].valid ? 0 : 1;
                    cur       = (kind == 0) ? rd_slot[c] : wr_slot[c];
                    active    = 1'b1;
                    phase     = P_REQ;
                    beat      = 0;
                    is_atop_r = 1'b0;
                    first     = 1'b1;
                    busy      = 0;
                    grant_log.push_back(c);
                    kind_log.push_back(kind);
                    break;
                end
            end
            return;
        end

        busy++;
        if (busy > WDOG) begin
            check("watchdog_txn_stuck", 64'(busy), 64'(0));
            active = 1'b0;
            return;
        end

        q = 1'b0;
        for (int i = 0; i < NUM; i++) if (i != g) q |= |slv_resp[i];
        check("nongnt_quiet", 64'(q), 64'(0));

        case (phase)
            P_REQ: begin
                if (kind == 0) begin
                    check("ar_valid_fwd", 64'(mst_req.ar_valid), 64'(1));
                    check("aw_valid_off", 64'(mst_req.aw_valid), 64'(0));
                    check("ar_ready_ret", 64'(slv_resp[g].ar_ready), 64'(ccu_ar_ready));
                    if (first) begin
                        check("ar_id", 64'(mst_req.ar.id), 64'({2'(g), cur.id}));
                        check("ar_addr", 64'(mst_req.ar.addr), 64'(cur.addr));
                    end
                    if (ccu_ar_ready) begin
                        rd_slot[g].valid = 1'b0;
                        phase = P_R;
                        beat  = 0;
                    end
                end else begin
                    check("aw_valid_fwd", 64'(mst_req.aw_valid), 64'(1));
                    check("ar_valid_off", 64'(mst_req.ar_valid), 64'(0));
                    check("aw_ready_ret", 64'(slv_resp[g].aw_ready), 64'(ccu_aw_ready));
                    if (first) begin
                        check("aw_id", 64'(mst_req.aw.id), 64'({2'(g), cur.id}));
                        check("aw_atop5", 64'(mst_req.aw.atop[5]), 64'(cur.atop));
                    end
                    if (ccu_aw_ready) begin
                        wr_slot[g].valid = 1'b0;
                        phase = P_W;
                        beat  = 0;
                    end
                end
                first = 1'b0;
            end
            P_R: begin
                check("r_valid_fwd", 64'(slv_resp[g].r_valid), 64'(ccu_r_valid));
                check("r_ready_fwd", 64'(mst_req.r_ready), 64'(m_r_ready[g]));
                if (ccu_r_valid) begin
                    check("r_id_strip", 64'(slv_resp[g].r.id), 64'(cur.id));
                    check("r_data", 64'(slv_resp[g].r.data), 64'(r_data_exp()));
                    check("r_last", 64'(slv_resp[g].r.last), 64'(beat == rlen()));
                end
                if (ccu_r_valid && m_r_ready[g]) begin
                    if (is_atop_r) atop_beats++;
                    if (beat == rlen()) complete();
                    else beat++;
                end
            end
            P_W: begin
                check("w_valid_fwd", 64'(mst_req.w_valid), 64'(m_w_valid));
                check("w_ready_ret", 64'(slv_resp[g].w_ready), 64'(ccu_w_ready));
                if (m_w_valid) begin
                    check("w_data", 64'(mst_req.w.data), 64'(cur.addr + 32'(beat)));
                    check("w_last", 64'(mst_req.w.last), 64'(beat == int'(cur.len)));
                end
                if (m_w_valid && ccu_w_ready) begin
                    if (beat == int'(cur.len)) phase = P_B;
                    else beat++;
                end
            end
            P_B: begin
                check("b_valid_fwd", 64'(slv_resp[g].b_valid), 64'(1));
                check("b_id_strip", 64'(slv_resp[g].b.id), 64'(cur.id));
                check("b_ready_fwd", 64'(mst_req.b_ready), 64'(m_b_ready[g]));
                if (m_b_ready[g]) begin
                    if (cur.atop) begin
                        phase     = P_R;
                        is_atop_r = 1'b1;
                        beat      = 0;
                    end else begin
                        complete();
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(negedge clk_i);
        inject();
        drive();
        #1;
        evaluate();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((active || any_pending()) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_done", 64'(active || any_pending()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i    = 1'b1;
        for (int i = 0; i < NUM; i++) slv_req[i] = '0;
        mst_resp = '0;
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            rd_slot[i].valid = 1'b0;
            wr_slot[i].valid = 1'b0;
        end
        active     = 1'b0;
        rr         = 0;
        mode       = 0;
        atop_beats = 0;
        grant_log.delete();
        kind_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        for (int i = 0; i < NUM; i++) begin
            slv_req[i] = '0;
            rd_slot[i].valid = 1'b0;
            wr_slot[i].valid = 1'b0;
        end
        mst_resp = '0;
        done_cnt = 0;
        repeat (2) @(posedge clk_i);
        do_reset();

        // Single read from master 2: one idle cycle, widened ID, four beats.
        rd_slot[2] = '{valid: 1'b1, id: 4'h5, addr: 32'h0000_1000, len: 8'd3, atop: 1'b0};
        step();
        check("tp1_idle_latency", 64'(mst_req.ar_valid), 64'(0));
        step();
        check("tp1_ar_id", 64'(mst_req.ar.id), 64'h25);
        drain(200);
        check("tp1_grants", 64'(grant_log.size()), 64'(1));

        // Three simultaneous readers, pointer at 0: served 0, 1, 3.
        do_reset();
        rd_slot[0] = new_txn(1'b0);
        rd_slot[1] = new_txn(1'b0);
        rd_slot[3] = new_txn(1'b0);
        drain(600);
        check("tp2_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3) begin
            check("tp2_g0", 64'(grant_log[0]), 64'(0));
            check("tp2_g1", 64'(grant_log[1]), 64'(1));
            check("tp2_g2", 64'(grant_log[2]), 64'(3));
        end

        // Read and write from one master: read first, then write.
        do_reset();
        rd_slot[1] = new_txn(1'b0);
        wr_slot[1] = new_txn(1'b1);
        wr_slot[1].atop = 1'b0;
        drain(600);
        check("tp3_count", 64'(kind_log.size()), 64'(2));
        if (kind_log.size() == 2) begin
            check("tp3_first_read", 64'(kind_log[0]), 64'(0));
            check("tp3_then_write", 64'(kind_log[1]), 64'(1));
        end

        // Atomic write from master 0: W, B, then R data before returning.
        do_reset();
        wr_slot[0] = '{valid: 1'b1, id: 4'h3, addr: 32'h0000_2000, len: 8'd1, atop: 1'b1};
        drain(400);
        check("tp4_atop_r_beats", 64'(atop_beats), 64'(1));

        // Reset in the middle of an R burst: back to idle, pointer at 0.
        do_reset();
        rd_slot[2] = new_txn(1'b0);
        drain(200);
        rd_slot[2] = '{valid: 1'b1, id: 4'h9, addr: 32'h0000_3000, len: 8'd3, atop: 1'b0};
        n = 0;
        while (!(active && phase == P_R && beat == 2) && n < 300) begin
            step();
            n++;
        end
        check("tp5_reached_beat2", 64'(active && phase == P_R && beat == 2), 64'(1));
        do_reset();
        for (int i = 0; i < NUM; i++) rd_slot[i] = new_txn(1'b0);
        drain(800);
        check("tp5_count", 64'(grant_log.size()), 64'(4));
        for (int k = 0; k < grant_log.size() && k < 4; k++) begin
            check("tp5_order", 64'(grant_log[k]), 64'(k));
        end

        // Masters 0 and 3 requesting back to back: grants must alternate.
        do_reset();
        mode = 2;
        repeat (300) step();
        mode = 0;
        drain(400);
        check("tp6_enough_grants", 64'(grant_log.size() >= 6), 64'(1));
        for (int k = 0; k < grant_log.size(); k++) begin
            check("tp6_alternate", 64'(grant_log[k]), 64'((k % 2 == 0) ? 0 : 3));
        end

        // Random traffic on all masters.
        do_reset();
        done_cnt = 0;
        mode = 1;
        repeat (3000) step();
        mode = 0;
        drain(2000);
        check("rand_progress", 64'(done_cnt > 20), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
